execute_stage_module: RTL and testbench

- Execute (EX) stage of the 5-stage RISC-V pipeline. Sits directly downstream of the decode stage and consumes its ID/EX register outputs.
- Resolves forwarding operand muxes, runs the ALU, and computes the beq branch decision and target.
- Registers results into the EX/MEM pipeline register, which feeds the memory stage.

---
 rtl/riscv_pipe_pkg.sv | 22 ++
 rtl/alu_unit.sv | 29 ++
 rtl/execute_stage_module.sv | 104 ++++++++++
 tb/tb_execute_stage_module.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the RISC-V pipeline: ALU operation codes,
// forwarding-select encodings and the default datapath width.
package riscv_pipe_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    // 2'b11 is reserved and decodes the same as FWD_RF.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/alu_unit.sv
// Combinational ALU for the execute stage; result is mod 2^XLEN and
// Zero flags an all-zero result for the beq decision.
module alu_unit
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = SrcA + SrcB;
            ALU_SUB: Result = SrcA - SrcB;
            ALU_AND: Result = SrcA & SrcB;
            ALU_OR:  Result = SrcA | SrcB;
            ALU_SLT: Result = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_stage_module.sv
// EX stage: forwarding muxes, ALU, beq decision/target, and the EX/MEM
// pipeline register feeding the memory stage.
module execute_stage_module
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEFAULT,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteE,
    input  logic                  ResultSrcE,
    input  logic                  MemWriteE,
    input  logic                  BranchE,
    input  logic                  ALUSrcE,
    input  logic [2:0]            ALUControlE,
    input  logic [XLEN-1:0]       RD1_E,
    input  logic [XLEN-1:0]       RD2_E,
    input  logic [XLEN-1:0]       ImmExtE,
    input  logic [XLEN-1:0]       PCE,
    input  logic [XLEN-1:0]       PCPlus4E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [XLEN-1:0]       ResultW,
    input  logic [1:0]            ForwardAE,
    input  logic [1:0]            ForwardBE,
    output logic                  PCSrcE,
    output logic [XLEN-1:0]       PCTargetE,
    output logic                  RegWriteM,
    output logic                  ResultSrcM,
    output logic                  MemWriteM,
    output logic [XLEN-1:0]       ALUResultM,
    output logic [XLEN-1:0]       WriteDataM,
    output logic [REG_ADDR_W-1:0] RdM,
    output logic [XLEN-1:0]       PCPlus4M
);

    logic [XLEN-1:0]       src_a, fwd_b, src_b, alu_result;
    logic                  alu_zero;

    logic                  reg_write_q, result_src_q, mem_write_q;
    logic [XLEN-1:0]       alu_result_q, write_data_q, pc_plus4_q;
    logic [REG_ADDR_W-1:0] rd_q;

    // MEM forwarding taps the registered result, i.e. the previous instruction.
    always_comb begin
        src_a = RD1_E;
        case (ForwardAE)
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = alu_result_q;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        fwd_b = RD2_E;
        case (ForwardBE)
            FWD_WB:  fwd_b = ResultW;
            FWD_MEM: fwd_b = alu_result_q;
            default: fwd_b = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? ImmExtE : fwd_b;

    alu_unit #(.XLEN(XLEN)) u_alu (
        .SrcA       (src_a),
        .SrcB       (src_b),
        .ALUControl (ALUControlE),
        .Result     (alu_result),
        .Zero       (alu_zero)
    );

    assign PCSrcE    = BranchE & alu_zero;
    assign PCTargetE = PCE + ImmExtE;

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_result_q <= '0;
            write_data_q <= '0;
            rd_q         <= '0;
            pc_plus4_q   <= '0;
        end else begin
            reg_write_q  <= RegWriteE;
            result_src_q <= ResultSrcE;
            mem_write_q  <= MemWriteE;
            alu_result_q <= alu_result;
            write_data_q <= fwd_b;
            rd_q         <= RdE;
            pc_plus4_q   <= PCPlus4E;
        end
    end

    assign RegWriteM  = reg_write_q;
    assign ResultSrcM = result_src_q;
    assign MemWriteM  = mem_write_q;
    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign RdM        = rd_q;
    assign PCPlus4M   = pc_plus4_q;

endmodule

// File: tb/tb_execute_stage_module.sv
// Directed-vector bench for execute_stage_module with hand-computed
// expectations for the ALU, forwarding, store data, branch and reset.
module tb_execute_stage_module;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E, ResultW;
    logic [4:0]  RdE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, ResultSrcM, MemWriteM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    execute_stage_module #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .RegWriteE   (RegWriteE),
        .ResultSrcE  (ResultSrcE),
        .MemWriteE   (MemWriteE),
        .BranchE     (BranchE),
        .ALUSrcE     (ALUSrcE),
        .ALUControlE (ALUControlE),
        .RD1_E       (RD1_E),
        .RD2_E       (RD2_E),
        .ImmExtE     (ImmExtE),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E),
        .RdE         (RdE),
        .ResultW     (ResultW),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .RegWriteM   (RegWriteM),
        .ResultSrcM  (ResultSrcM),
        .MemWriteM   (MemWriteM),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .RdM         (RdM),
        .PCPlus4M    (PCPlus4M)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic [2:0] op, input logic src, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] imm,
                      input logic [1:0] fa, input logic [1:0] fb);
        ALUControlE = op;
        ALUSrcE     = src;
        RD1_E       = a;
        RD2_E       = b;
        ImmExtE     = imm;
        ForwardAE   = fa;
        ForwardBE   = fb;
    endtask

    task automatic check_m_zero(input string tag);
        check({tag, "_rw"},  {31'd0, RegWriteM},  32'd0);
        check({tag, "_rs"},  {31'd0, ResultSrcM}, 32'd0);
        check({tag, "_mw"},  {31'd0, MemWriteM},  32'd0);
        check({tag, "_alu"}, ALUResultM,          32'd0);
        check({tag, "_wd"},  WriteDataM,          32'd0);
        check({tag, "_rd"},  {27'd0, RdM},        32'd0);
        check({tag, "_pc4"}, PCPlus4M,            32'd0);
    endtask

    initial begin
        // Reset with nonzero inputs present
        rst = 1'b1;
        RegWriteE = 1'b1; ResultSrcE = 1'b1; MemWriteE = 1'b0; BranchE = 1'b0;
        PCE = 32'h0000_1000; PCPlus4E = 32'h0000_1004; RdE = 5'd3; ResultW = 32'h0;
        ex(3'b000, 1'b1, 32'd5, 32'h55, 32'd7, 2'b00, 2'b00);
        tick();
        check_m_zero("rst1");
        tick();
        check_m_zero("rst2");

        // Release: next edge captures add-immediate
        rst = 1'b0;
        tick();
        check("addi_alu", ALUResultM, 32'd12);
        check("addi_rd", {27'd0, RdM}, 32'd3);
        check("addi_rw", {31'd0, RegWriteM}, 32'd1);
        check("addi_rs", {31'd0, ResultSrcM}, 32'd1);
        check("addi_wd", WriteDataM, 32'h55);
        check("addi_pc4", PCPlus4M, 32'h1004);

        // Signed slt, both orders
        ResultSrcE = 1'b0;
        ex(3'b101, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 2'b00, 2'b00);
        tick();
        check("slt_neg", ALUResultM, 32'd1);
        ex(3'b101, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 2'b00, 2'b00);
        tick();
        check("slt_swap", ALUResultM, 32'd0);

        // Forwarding: set ALUResultM = 0x20, then A from MEM, B from WB
        ex(3'b000, 1'b1, 32'h20, 32'd0, 32'd0, 2'b00, 2'b00);
        tick();
        check("fwd_prep", ALUResultM, 32'h20);
        ResultW = 32'h5;
        ex(3'b001, 1'b0, 32'h777, 32'h999, 32'd0, 2'b10, 2'b01);
        tick();
        check("fwd_sub", ALUResultM, 32'h1B);
        check("fwd_wd", WriteDataM, 32'h5);

        // Reserved select 11 behaves as register-file operand
        ex(3'b000, 1'b0, 32'd3, 32'd9, 32'd0, 2'b11, 2'b11);
        tick();
        check("fwd11_alu", ALUResultM, 32'd12);
        check("fwd11_wd", WriteDataM, 32'd9);

        // Back-to-back: MEM forward uses the pre-edge value (12)
        ex(3'b000, 1'b1, 32'd0, 32'd0, 32'd1, 2'b10, 2'b00);
        tick();
        check("b2b_1", ALUResultM, 32'd13);
        tick();
        check("b2b_2", ALUResultM, 32'd14);

        // Store: write data is forwarded B, not the immediate
        MemWriteE = 1'b1; RegWriteE = 1'b0; RdE = 5'd0; ResultW = 32'hABCD;
        ex(3'b000, 1'b1, 32'h100, 32'h1111, 32'd8, 2'b00, 2'b01);
        tick();
        check("st_alu", ALUResultM, 32'h108);
        check("st_wd", WriteDataM, 32'hABCD);
        check("st_mw", {31'd0, MemWriteM}, 32'd1);
        check("st_rw", {31'd0, RegWriteM}, 32'd0);
        MemWriteE = 1'b0;

        // Logic ops, unused code, subtract wrap
        ex(3'b010, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 2'b00, 2'b00);
        tick();
        check("and", ALUResultM, 32'h0000_F000);
        ex(3'b011, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 2'b00, 2'b00);
        tick();
        check("or", ALUResultM, 32'h0000_FFF0);
        ex(3'b111, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 2'b00, 2'b00);
        tick();
        check("op111", ALUResultM, 32'd0);
        ex(3'b100, 1'b0, 32'd7, 32'd7, 32'd0, 2'b00, 2'b00);
        tick();
        check("op100", ALUResultM, 32'd0);
        ex(3'b001, 1'b0, 32'd0, 32'd1, 32'd0, 2'b00, 2'b00);
        tick();
        check("sub_wrap", ALUResultM, 32'hFFFF_FFFF);

        // Branch decision and target, same cycle
        BranchE = 1'b1; PCE = 32'h40;
        ex(3'b001, 1'b0, 32'd4, 32'd4, 32'hFFFF_FFF0, 2'b00, 2'b00);
        #1;
        check("beq_taken", {31'd0, PCSrcE}, 32'd1);
        check("beq_target", PCTargetE, 32'h30);
        RD2_E = 32'd5;
        #1;
        check("beq_not", {31'd0, PCSrcE}, 32'd0);
        BranchE = 1'b0; RD2_E = 32'd4;
        #1;
        check("nobranch_zero", {31'd0, PCSrcE}, 32'd0);
        PCE = 32'hFFFF_FFF0; ImmExtE = 32'h20;
        #1;
        check("target_wrap", PCTargetE, 32'h10);

        // Mid-stream reset drops the in-flight instruction; branch logic unaffected
        BranchE = 1'b1; RegWriteE = 1'b1; ResultSrcE = 1'b1; MemWriteE = 1'b1;
        RdE = 5'd9; PCPlus4E = 32'h2004; PCE = 32'h40;
        ex(3'b001, 1'b0, 32'd4, 32'd4, 32'hFFFF_FFF0, 2'b00, 2'b00);
        rst = 1'b1;
        tick();
        check_m_zero("rst_mid");
        check("rst_pcsrc", {31'd0, PCSrcE}, 32'd1);
        check("rst_target", PCTargetE, 32'h30);

        // Bubble: all-zero controls pass through
        rst = 1'b0; BranchE = 1'b0;
        RegWriteE = 1'b0; ResultSrcE = 1'b0; MemWriteE = 1'b0; RdE = 5'd0;
        ex(3'b000, 1'b0, 32'd0, 32'd0, 32'd0, 2'b10, 2'b10);
        tick();
        check("bubble_rw", {31'd0, RegWriteM}, 32'd0);
        check("bubble_mw", {31'd0, MemWriteM}, 32'd0);
        check("bubble_alu", ALUResultM, 32'd0);
        check("bubble_pc4", PCPlus4M, 32'h2004);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
